order_book: RTL and testbench

- Limit order book for a single instrument; sits downstream of the message parser's output FIFO.
- Consumes one parsed message (add / update / delete) per accepted cycle.
- Maintains two price-sorted order arrays (bid, ask).
- Presents best bid and best ask price and quantity continuously.

---
 rtl/order_book_pkg.sv | 11 +
 rtl/parser_defs.sv | 32 +++
 rtl/order_book_if.sv | 11 +
 rtl/order_book_side.sv | 108 ++++++++++
 rtl/order_book.sv | 70 +++++++
 tb/tb_order_book.sv | 190 +++++++++++++++++++
 6 files changed

// File: rtl/order_book_pkg.sv
// Order-book helpers: price priority shared by both sides of the book.
package order_book_pkg;

  // True when a resting order at 'held' stays ahead of a new order at 'incoming';
  // ties favour the resting order so arrival order is preserved.
  function automatic logic ranks_ahead(input logic is_bid, input logic [31:0] held,
                                       input logic [31:0] incoming);
    return is_bid ? (held >= incoming) : (held <= incoming);
  endfunction

endpackage

// File: rtl/parser_defs.sv
// Message-parser types shared by everything downstream of the parser FIFO.
package parser_defs_pkg;

  typedef enum logic [7:0] {
    MSG_ADD    = 8'h41,
    MSG_UPDATE = 8'h55,
    MSG_DELETE = 8'h44
  } msg_type_t;

  typedef enum logic [7:0] {
    ORDER_SIDE_BID = 8'h42,
    ORDER_SIDE_ASK = 8'h53
  } order_side_t;

  typedef struct packed {
    msg_type_t   msg_type;
    logic [7:0]  stock_locate;
    logic [31:0] order_id;
    order_side_t side;
    logic [31:0] price;
    logic [31:0] quantity;
    logic [7:0]  trailer;
  } parsed_msg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] order_id;
    logic [31:0] price;
    logic [31:0] quantity;
  } order_entry_t;

endpackage

// File: rtl/order_book_if.sv
// Consume-side handshake between the parser output FIFO and the order book.
interface order_book_if;
  import parser_defs_pkg::*;

  logic        read_en;
  logic        empty;
  parsed_msg_t parsed_message;

  modport master (output read_en, output empty, output parsed_message);
  modport slave  (input read_en, input empty, input parsed_message);
endinterface

// File: rtl/order_book_side.sv
// One side of the book: a packed, price-sorted order array with single-cycle
// add/update/delete. Optional ORDER_BOOK_STATS_EN adds count and drop outputs.
module order_book_side
  import parser_defs_pkg::*;
  import order_book_pkg::*;
#(
  parameter int unsigned MAX_ORDERS = 16,
  parameter bit          IS_BID     = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  msg_type_t    msg_type,
  input  logic [31:0]  order_id,
  input  logic [31:0]  price,
  input  logic [31:0]  quantity,
`ifdef ORDER_BOOK_STATS_EN
  output logic [$clog2(MAX_ORDERS+1)-1:0] count,
  output logic         drop,
`endif
  output order_entry_t orders [MAX_ORDERS]
);

  logic         hit, full, do_remove, do_insert, qty_only;
  int unsigned  hit_idx, pos;
  order_entry_t rem [MAX_ORDERS];
  order_entry_t nxt [MAX_ORDERS];

  assign full = orders[MAX_ORDERS-1].valid;

  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    for (int unsigned i = 0; i < MAX_ORDERS; i++) begin
      if (!hit && orders[i].valid && orders[i].order_id == order_id) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end

    do_remove = 1'b0;
    do_insert = 1'b0;
    qty_only  = 1'b0;
    if (en) begin
      case (msg_type)
        MSG_ADD:    do_insert = !hit && !full;
        MSG_UPDATE: begin
          if (hit && orders[hit_idx].price != price) begin
            do_remove = 1'b1;
            do_insert = 1'b1;
          end else begin
            qty_only = hit;
          end
        end
        MSG_DELETE: do_remove = hit;
        default:    ;
      endcase
    end

    // A repriced update is a delete followed by a fresh insert on the compacted array.
    rem = orders;
    if (do_remove) begin
      for (int unsigned i = 0; i < MAX_ORDERS - 1; i++) begin
        if (i >= hit_idx) rem[i] = orders[i+1];
      end
      rem[MAX_ORDERS-1] = '0;
    end

    pos = 0;
    for (int unsigned i = 0; i < MAX_ORDERS; i++) begin
      if (rem[i].valid && ranks_ahead(IS_BID, rem[i].price, price)) pos = pos + 1;
    end

    nxt = rem;
    if (do_insert) begin
      for (int unsigned i = 1; i < MAX_ORDERS; i++) begin
        if (i > pos) nxt[i] = rem[i-1];
      end
      for (int unsigned i = 0; i < MAX_ORDERS; i++) begin
        if (i == pos) nxt[i] = '{valid: 1'b1, order_id: order_id, price: price, quantity: quantity};
      end
    end
    if (qty_only) nxt[hit_idx].quantity = quantity;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MAX_ORDERS; i++) orders[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < MAX_ORDERS; i++) orders[i] <= nxt[i];
    end
  end

`ifdef ORDER_BOOK_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop <= 1'b0;
    else        drop <= en && (msg_type == MSG_ADD) && full;
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < MAX_ORDERS; i++) begin
      if (orders[i].valid) count = count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/order_book.sv
// Single-instrument limit order book: decodes parser messages onto the bid/ask
// sides and presents best prices. ORDER_BOOK_STATS_EN adds counts and drop_pulse.
module order_book
  import parser_defs_pkg::*;
#(
  parameter int unsigned MAX_ORDERS = 16
) (
  input  logic        clk,
  input  logic        reset,
  order_book_if.slave msg,
  output logic [31:0] best_bid_price,
  output logic [31:0] best_ask_price,
  output logic [31:0] best_bid_quantity,
`ifdef ORDER_BOOK_STATS_EN
  output logic [$clog2(MAX_ORDERS+1)-1:0] bid_count,
  output logic [$clog2(MAX_ORDERS+1)-1:0] ask_count,
  output logic        drop_pulse,
`endif
  output logic [31:0] best_ask_quantity
);

  order_entry_t bid_orders [MAX_ORDERS];
  order_entry_t ask_orders [MAX_ORDERS];
  logic         accept, bid_en, ask_en;

  assign accept = msg.read_en && !msg.empty;
  assign bid_en = accept && (msg.parsed_message.side == ORDER_SIDE_BID);
  assign ask_en = accept && (msg.parsed_message.side == ORDER_SIDE_ASK);

`ifdef ORDER_BOOK_STATS_EN
  logic bid_drop, ask_drop;
  assign drop_pulse = bid_drop | ask_drop;
`endif

  order_book_side #(.MAX_ORDERS(MAX_ORDERS), .IS_BID(1'b1)) bid_side (
    .clk      (clk),
    .reset    (reset),
    .en       (bid_en),
    .msg_type (msg.parsed_message.msg_type),
    .order_id (msg.parsed_message.order_id),
    .price    (msg.parsed_message.price),
    .quantity (msg.parsed_message.quantity),
`ifdef ORDER_BOOK_STATS_EN
    .count    (bid_count),
    .drop     (bid_drop),
`endif
    .orders   (bid_orders)
  );

  order_book_side #(.MAX_ORDERS(MAX_ORDERS), .IS_BID(1'b0)) ask_side (
    .clk      (clk),
    .reset    (reset),
    .en       (ask_en),
    .msg_type (msg.parsed_message.msg_type),
    .order_id (msg.parsed_message.order_id),
    .price    (msg.parsed_message.price),
    .quantity (msg.parsed_message.quantity),
`ifdef ORDER_BOOK_STATS_EN
    .count    (ask_count),
    .drop     (ask_drop),
`endif
    .orders   (ask_orders)
  );

  assign best_bid_price    = bid_orders[0].valid ? bid_orders[0].price    : '0;
  assign best_bid_quantity = bid_orders[0].valid ? bid_orders[0].quantity : '0;
  assign best_ask_price    = ask_orders[0].valid ? ask_orders[0].price    : '0;
  assign best_ask_quantity = ask_orders[0].valid ? ask_orders[0].quantity : '0;

endmodule

// File: tb/tb_order_book.sv
// Directed bench for order_book: ordering, update, delete, full side, reset.
module tb_order_book;
  import parser_defs_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] best_bid_price, best_ask_price, best_bid_quantity, best_ask_quantity;
  int          checks = 0;
  int          errors = 0;

`ifdef ORDER_BOOK_STATS_EN
  logic [4:0] bid_count, ask_count;
  logic       drop_pulse;
`endif

  order_book_if bus ();

  order_book #(.MAX_ORDERS(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .msg               (bus),
    .best_bid_price    (best_bid_price),
    .best_ask_price    (best_ask_price),
    .best_bid_quantity (best_bid_quantity),
`ifdef ORDER_BOOK_STATS_EN
    .bid_count         (bid_count),
    .ask_count         (ask_count),
    .drop_pulse        (drop_pulse),
`endif
    .best_ask_quantity (best_ask_quantity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input msg_type_t t, input order_side_t s, input logic [31:0] id,
                      input logic [31:0] p, input logic [31:0] q, input logic emp = 1'b0);
    @(negedge clk);
    bus.parsed_message = '{msg_type: t, stock_locate: 8'h01, order_id: id, side: s,
                           price: p, quantity: q, trailer: 8'h0A};
    bus.read_en = 1'b1;
    bus.empty   = emp;
    @(posedge clk);
    #1;
    bus.read_en = 1'b0;
    bus.empty   = 1'b1;
  endtask

  initial begin
    bus.read_en = 1'b0;
    bus.empty   = 1'b1;
    bus.parsed_message = '0;
    #12;
    check("rst_bid_px", best_bid_price, 32'd0);
    check("rst_bid_qty", best_bid_quantity, 32'd0);
    check("rst_ask_px", best_ask_price, 32'd0);
    check("rst_ask_qty", best_ask_quantity, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // bid ordering
    send(MSG_ADD, ORDER_SIDE_BID, 32'h11111111, 32'd1000, 32'd10);
    check("bid_first_px", best_bid_price, 32'd1000);
    send(MSG_ADD, ORDER_SIDE_BID, 32'h22222222, 32'd1050, 32'd5);
    send(MSG_ADD, ORDER_SIDE_BID, 32'h33333333, 32'd990, 32'd20);
    check("bid_s0", dut.bid_orders[0].price, 32'd1050);
    check("bid_s1", dut.bid_orders[1].price, 32'd1000);
    check("bid_s2", dut.bid_orders[2].price, 32'd990);
    check("best_bid_px", best_bid_price, 32'd1050);
    check("best_bid_qty", best_bid_quantity, 32'd5);
    check("ask_untouched", best_ask_price, 32'd0);

    // ask ordering
    send(MSG_ADD, ORDER_SIDE_ASK, 32'hAAAAAAAA, 32'd1100, 32'd15);
    send(MSG_ADD, ORDER_SIDE_ASK, 32'hBBBBBBBB, 32'd1080, 32'd10);
    send(MSG_ADD, ORDER_SIDE_ASK, 32'hCCCCCCCC, 32'd1150, 32'd5);
    check("ask_s0", dut.ask_orders[0].price, 32'd1080);
    check("ask_s1", dut.ask_orders[1].price, 32'd1100);
    check("ask_s2", dut.ask_orders[2].price, 32'd1150);
    check("best_ask_px", best_ask_price, 32'd1080);
    check("best_ask_qty", best_ask_quantity, 32'd10);

    // updates
    send(MSG_UPDATE, ORDER_SIDE_BID, 32'h11111111, 32'd1000, 32'd999);
    check("upd_bid_qty", dut.bid_orders[1].quantity, 32'd999);
    check("upd_bid_best", best_bid_price, 32'd1050);
    check("upd_bid_bestq", best_bid_quantity, 32'd5);
    send(MSG_UPDATE, ORDER_SIDE_ASK, 32'hBBBBBBBB, 32'd1075, 32'd11);
    check("upd_ask_px", best_ask_price, 32'd1075);
    check("upd_ask_qty", best_ask_quantity, 32'd11);
    check("upd_ask_s1", dut.ask_orders[1].order_id, 32'hAAAAAAAA);
    send(MSG_UPDATE, ORDER_SIDE_ASK, 32'h12345678, 32'd1, 32'd1);
    check("upd_unknown", dut.ask_orders[2].order_id, 32'hCCCCCCCC);

    // deletes
    send(MSG_DELETE, ORDER_SIDE_BID, 32'h11111111, 32'd0, 32'd0);
    check("del_bid_s0", dut.bid_orders[0].price, 32'd1050);
    check("del_bid_s1", dut.bid_orders[1].price, 32'd990);
    check("del_bid_s2v", dut.bid_orders[2].valid, 32'd0);
    send(MSG_DELETE, ORDER_SIDE_ASK, 32'hBBBBBBBB, 32'd0, 32'd0);
    check("del_ask_px", best_ask_price, 32'd1100);
    check("del_ask_qty", best_ask_quantity, 32'd15);
    check("del_ask_s1", dut.ask_orders[1].price, 32'd1150);
    check("del_ask_s2v", dut.ask_orders[2].valid, 32'd0);

    // repriced update moves the order
    send(MSG_UPDATE, ORDER_SIDE_ASK, 32'hCCCCCCCC, 32'd1090, 32'd7);
    check("mv_s0_id", dut.ask_orders[0].order_id, 32'hCCCCCCCC);
    check("mv_s0_qty", dut.ask_orders[0].quantity, 32'd7);
    check("mv_s1_id", dut.ask_orders[1].order_id, 32'hAAAAAAAA);
    check("mv_s2v", dut.ask_orders[2].valid, 32'd0);

    // no-effect cases
    send(MSG_DELETE, ORDER_SIDE_ASK, 32'h0000DEAD, 32'd0, 32'd0);
    check("del_unk_s1", dut.ask_orders[1].price, 32'd1100);
    send(MSG_ADD, ORDER_SIDE_ASK, 32'h00000077, 32'd1000, 32'd1, 1'b1);
    check("empty_px", best_ask_price, 32'd1090);
    check("empty_s2v", dut.ask_orders[2].valid, 32'd0);
    send(msg_type_t'(8'h58), ORDER_SIDE_ASK, 32'hAAAAAAAA, 32'd1, 32'd1);
    check("badtype_s1", dut.ask_orders[1].price, 32'd1100);
    send(MSG_ADD, ORDER_SIDE_ASK, 32'hAAAAAAAA, 32'd1000, 32'd3);
    check("dup_add_px", best_ask_price, 32'd1090);

    // equal price keeps arrival order
    send(MSG_ADD, ORDER_SIDE_BID, 32'h44444444, 32'd1050, 32'd1);
    check("eq_s0", dut.bid_orders[0].order_id, 32'h22222222);
    check("eq_s1", dut.bid_orders[1].order_id, 32'h44444444);
    check("eq_s2", dut.bid_orders[2].price, 32'd990);

    // emptying a side
    send(MSG_DELETE, ORDER_SIDE_ASK, 32'hCCCCCCCC, 32'd0, 32'd0);
    send(MSG_DELETE, ORDER_SIDE_ASK, 32'hAAAAAAAA, 32'd0, 32'd0);
    check("empty_ask_px", best_ask_price, 32'd0);
    check("empty_ask_qty", best_ask_quantity, 32'd0);

    // fill bid side: 3 resting + 13 more
    for (int k = 0; k < 13; k++)
      send(MSG_ADD, ORDER_SIDE_BID, 32'h100 + k, 32'd500 + k, 32'd1);
    check("full_s15v", dut.bid_orders[15].valid, 32'd1);
    check("full_s15px", dut.bid_orders[15].price, 32'd500);
`ifdef ORDER_BOOK_STATS_EN
    check("full_count", bid_count, 32'd16);
    check("nodrop", drop_pulse, 32'd0);
`endif
    send(MSG_ADD, ORDER_SIDE_BID, 32'h00000999, 32'd2000, 32'd9);
    check("drop_best", best_bid_price, 32'd1050);
    check("drop_s0id", dut.bid_orders[0].order_id, 32'h22222222);
    check("drop_s15id", dut.bid_orders[15].order_id, 32'h100);
`ifdef ORDER_BOOK_STATS_EN
    check("drop_pulse", drop_pulse, 32'd1);
    check("drop_count", bid_count, 32'd16);
    @(posedge clk); #1;
    check("drop_clear", drop_pulse, 32'd0);
`endif

    // reset during an accept cycle
    @(negedge clk);
    bus.parsed_message = '{msg_type: MSG_ADD, stock_locate: 8'h01, order_id: 32'h55, side: ORDER_SIDE_ASK,
                           price: 32'd1200, quantity: 32'd3, trailer: 8'h0A};
    bus.read_en = 1'b1;
    bus.empty   = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_bid_px", best_bid_price, 32'd0);
    check("arst_bid_qty", best_bid_quantity, 32'd0);
    @(posedge clk); #1;
    check("arst_ask_px", best_ask_price, 32'd0);
    check("arst_s0v", dut.bid_orders[0].valid, 32'd0);
    check("arst_s15px", dut.bid_orders[15].price, 32'd0);
    bus.read_en = 1'b0;
    bus.empty   = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    send(MSG_ADD, ORDER_SIDE_ASK, 32'h55, 32'd1200, 32'd3);
    check("post_rst_px", best_ask_price, 32'd1200);
    check("post_rst_qty", best_ask_quantity, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
